// File: rtl/memory_arbiter.sv
// Shared RAM port arbiter for icache/dcache requests, data-priority by default.
// Define MEMARB_FAIR_EN to bound data streaks while an instruction fetch waits.
module memory_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef MEMARB_FAIR_EN
    ,
    parameter int MAX_DSTREAK = 4
`endif
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramack
);

    typedef enum logic [1:0] {IDLE, DACC, IACC, DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_wr;

    logic w_dreq;
    logic w_igrant;
    logic w_acc;
    logic w_dack;
    logic w_iack;

    assign w_dreq = dREN | dWEN;

`ifdef MEMARB_FAIR_EN
    localparam logic [2:0] LP_MAX = 3'(MAX_DSTREAK);

    logic [2:0] r_streak;

    assign w_igrant = iREN & (~w_dreq | (r_streak == LP_MAX));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_streak <= '0;
        end else if (r_state == IDLE) begin
            if (!iREN || w_igrant)
                r_streak <= '0;
            else if (w_dreq)
                r_streak <= r_streak + 3'd1;
        end
    end
`else
    assign w_igrant = iREN & ~w_dreq;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_wr    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_igrant) begin
                        r_state <= IACC;
                        r_addr  <= iaddr;
                        r_wr    <= 1'b0;
                    end else if (w_dreq) begin
                        r_state <= DACC;
                        r_addr  <= daddr;
                        r_wr    <= dWEN;
                        if (dWEN)
                            r_data <= dstore;
                    end
                end
                DACC, IACC: begin
                    if (ramack)
                        r_state <= DONE;
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM side sees only the latched access, so requester changes mid-access are harmless
    assign w_acc  = (r_state == DACC) | (r_state == IACC);
    assign w_dack = (r_state == DACC) & ramack;
    assign w_iack = (r_state == IACC) & ramack;

    assign ramREN   = w_acc & ~r_wr;
    assign ramWEN   = w_acc & r_wr;
    assign ramaddr  = w_acc ? r_addr : '0;
    assign ramstore = (w_acc & r_wr) ? r_data : '0;

    assign dwait = ~w_dack;
    assign dload = (w_dack & ~r_wr) ? ramload : '0;
    assign iwait = ~w_iack;
    assign iload = w_iack ? ramload : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: latency, priority, write hold, reset abort.
// Grant-order expectations follow MEMARB_FAIR_EN when it is defined.
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ramack;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_chk  = 0;
    int n_pass = 0;

    memory_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramack(ramack)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] exp_ord[6];
    logic [31:0] got_ord[6];
    int          n_gr;

    initial begin
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; ramack = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        tick(); tick();
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_ren", 32'(ramREN), 32'd0);
        chk("rst_wen", 32'(ramWEN), 32'd0);
        chk("rst_addr", ramaddr, 32'd0);
        chk("rst_store", ramstore, 32'd0);
        nRST = 1'b1;
        tick();

        // icache read, ack on third strobe cycle
        iREN = 1; iaddr = 32'h40; ramload = 32'hDEADBEEF;
        #1 chk("i_idle_ren", 32'(ramREN), 32'd0);
        tick();
        chk("i_s1_ren", 32'(ramREN), 32'd1);
        chk("i_s1_addr", ramaddr, 32'h40);
        chk("i_s1_iwait", 32'(iwait), 32'd1);
        tick();
        chk("i_s2_ren", 32'(ramREN), 32'd1);
        tick();
        ramack = 1;
        #1 chk("i_ack_iwait", 32'(iwait), 32'd0);
        chk("i_ack_iload", iload, 32'hDEADBEEF);
        chk("i_ack_ren", 32'(ramREN), 32'd1);
        chk("i_ack_dwait", 32'(dwait), 32'd1);
        tick();
        ramack = 0; iREN = 0;
        #1 chk("i_done_ren", 32'(ramREN), 32'd0);
        chk("i_done_iwait", 32'(iwait), 32'd1);
        chk("i_done_iload", iload, 32'd0);
        tick();

        // dcache write, requester drops dWEN after grant
        dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
        tick();
        dWEN = 0; daddr = 32'h0; dstore = 32'hFFFF;
        #1 chk("w_s1_wen", 32'(ramWEN), 32'd1);
        chk("w_s1_ren", 32'(ramREN), 32'd0);
        chk("w_s1_store", ramstore, 32'h1234);
        chk("w_s1_addr", ramaddr, 32'h80);
        chk("w_s1_dwait", 32'(dwait), 32'd1);
        tick();
        chk("w_s2_wen", 32'(ramWEN), 32'd1);
        tick();
        ramack = 1;
        #1 chk("w_ack_dwait", 32'(dwait), 32'd0);
        chk("w_ack_dload", dload, 32'd0);
        tick();
        ramack = 0;
        #1 chk("w_done_wen", 32'(ramWEN), 32'd0);
        chk("w_done_dwait", 32'(dwait), 32'd1);
        tick();

        // simultaneous requests: data first
        iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h100;
        ramload = 32'h55;
        tick();
        chk("p_d_addr", ramaddr, 32'h100);
        chk("p_d_ren", 32'(ramREN), 32'd1);
        ramack = 1;
        #1 chk("p_d_dwait", 32'(dwait), 32'd0);
        chk("p_d_dload", dload, 32'h55);
        chk("p_d_iwait", 32'(iwait), 32'd1);
        chk("p_d_iload", iload, 32'd0);
        tick();
        ramack = 0; dREN = 0;
        #1 chk("p_done_iwait", 32'(iwait), 32'd1);
        chk("p_done_ren", 32'(ramREN), 32'd0);
        tick();
        chk("p_idle_ren", 32'(ramREN), 32'd0);
        tick();
        chk("p_i_addr", ramaddr, 32'h200);
        ramack = 1; ramload = 32'h77;
        #1 chk("p_i_iload", iload, 32'h77);
        chk("p_i_dwait", 32'(dwait), 32'd1);
        tick();
        ramack = 0; iREN = 0;
        tick();

        // grant order under continuous contention
        for (int k = 0; k < 6; k++) exp_ord[k] = 32'h10;
`ifdef MEMARB_FAIR_EN
        exp_ord[4] = 32'h20;
`endif
        dREN = 1; iREN = 1; daddr = 32'h10; iaddr = 32'h20; ramack = 1;
        n_gr = 0;
        for (int k = 0; k < 18; k++) begin
            #1;
            if (ramREN && n_gr < 6) begin
                got_ord[n_gr] = ramaddr;
                n_gr++;
            end
            tick();
        end
        chk("ord_count", 32'(n_gr), 32'd6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("ord_%0d", k), got_ord[k], exp_ord[k]);
        dREN = 0; iREN = 0; ramack = 0;
        tick(); tick(); tick();

        // reset mid-DACC aborts, request re-granted afterwards
        dREN = 1; daddr = 32'h300;
        tick();
        chk("r_pre_ren", 32'(ramREN), 32'd1);
        #2 nRST = 1'b0;
        #1 chk("r_in_ren", 32'(ramREN), 32'd0);
        chk("r_in_wen", 32'(ramWEN), 32'd0);
        chk("r_in_dwait", 32'(dwait), 32'd1);
        chk("r_in_iwait", 32'(iwait), 32'd1);
        tick();
        nRST = 1'b1;
        tick();
        chk("r_post_ren", 32'(ramREN), 32'd1);
        chk("r_post_addr", ramaddr, 32'h300);
        ramack = 1;
        tick();
        ramack = 0; dREN = 0;
        tick();

        // ack while idle ignored; read+write acts as write
        ramack = 1; dREN = 1; dWEN = 1; daddr = 32'h400; dstore = 32'hABCD;
        #1 chk("x_idle_dwait", 32'(dwait), 32'd1);
        chk("x_idle_iwait", 32'(iwait), 32'd1);
        tick();
        ramack = 0;
        #1 chk("x_wen", 32'(ramWEN), 32'd1);
        chk("x_ren", 32'(ramREN), 32'd0);
        chk("x_store", ramstore, 32'hABCD);
        ramack = 1;
        #1 chk("x_ack_dwait", 32'(dwait), 32'd0);
        tick();
        ramack = 0; dREN = 0; dWEN = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
